// File: rtl/cache_arbiter_if.sv
// Bundles both caches' line-fill/write-back ports and the pmem port of the arbiter.
// slave: arbiter side; master: the cache/memory environment side.
interface cache_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
);
  logic                  icache_read;
  logic [ADDR_WIDTH-1:0] icache_address;
  logic [LINE_WIDTH-1:0] icache_rdata;
  logic                  icache_resp;

  logic                  dcache_read;
  logic                  dcache_write;
  logic [ADDR_WIDTH-1:0] dcache_address;
  logic [LINE_WIDTH-1:0] dcache_wdata;
  logic [LINE_WIDTH-1:0] dcache_rdata;
  logic                  dcache_resp;

  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport slave (
    input  icache_read, icache_address,
    output icache_rdata, icache_resp,
    input  dcache_read, dcache_write, dcache_address, dcache_wdata,
    output dcache_rdata, dcache_resp,
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output icache_read, icache_address,
    input  icache_rdata, icache_resp,
    output dcache_read, dcache_write, dcache_address, dcache_wdata,
    input  dcache_rdata, dcache_resp,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp
  );
endinterface

// File: rtl/cache_arbiter.sv
// Shares one pmem port between I- and D-cache, one whole-line transaction at a time; CACHE_ARB_RR_EN selects round-robin, else D has priority.
// Strobe one cycle after a request in IDLE, resp passes pmem_resp through combinationally; requesters simply wait while the other is served.
module cache_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  d_write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  i_pend, d_pend;
  logic                  grant_i, grant_d;
`ifdef CACHE_ARB_RR_EN
  logic                  last_grant_q;
`endif

  assign i_pend = bus.icache_read;
  assign d_pend = bus.dcache_read | bus.dcache_write;

  always_comb begin
    state_d          = state_q;
    grant_i          = 1'b0;
    grant_d          = 1'b0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.icache_resp  = 1'b0;
    bus.dcache_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_pend && d_pend) begin
`ifdef CACHE_ARB_RR_EN
          if (last_grant_q) grant_i = 1'b1;
          else              grant_d = 1'b1;
`else
          grant_d = 1'b1;
`endif
        end else if (i_pend) begin
          grant_i = 1'b1;
        end else if (d_pend) begin
          grant_d = 1'b1;
        end
      end
      SERVE_I: begin
        bus.pmem_read   = 1'b1;
        bus.icache_resp = bus.pmem_resp;
        if (bus.pmem_resp) begin
          if (d_pend) grant_d = 1'b1;
          else        state_d = IDLE;
        end
      end
      SERVE_D: begin
        bus.pmem_read   = ~d_write_q;
        bus.pmem_write  = d_write_q;
        bus.dcache_resp = bus.pmem_resp;
        // The D request is still high during its own resp, so only I may follow directly.
        if (bus.pmem_resp) begin
          if (i_pend) grant_i = 1'b1;
          else        state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant_i) state_d = SERVE_I;
    if (grant_d) state_d = SERVE_D;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      d_write_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
`ifdef CACHE_ARB_RR_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      if (grant_i) begin
        addr_q       <= bus.icache_address;
        wdata_q      <= '0;
        d_write_q    <= 1'b0;
`ifdef CACHE_ARB_RR_EN
        last_grant_q <= 1'b0;
`endif
      end else if (grant_d) begin
        addr_q       <= bus.dcache_address;
        wdata_q      <= bus.dcache_wdata;
        d_write_q    <= bus.dcache_write;
`ifdef CACHE_ARB_RR_EN
        last_grant_q <= 1'b1;
`endif
      end
    end
  end

  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
  assign bus.icache_rdata = bus.pmem_rdata;
  assign bus.dcache_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: vector table, directed corner sequences, then randomized traffic vs an ownership model.
module tb_cache_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();
  cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.icache_read    = 1'b0;
    bus.icache_address = '0;
    bus.dcache_read    = 1'b0;
    bus.dcache_write   = 1'b0;
    bus.dcache_address = '0;
    bus.dcache_wdata   = '0;
    bus.pmem_rdata     = '0;
    bus.pmem_resp      = 1'b0;
  endtask

  typedef struct {
    logic          ir, dr, dw, resp;
    logic [AW-1:0] ia, da;
    logic [LW-1:0] wd;
    logic          e_rd, e_wr, e_ir, e_dr;
    logic [AW-1:0] e_addr;
  } vec_t;

  function automatic vec_t mkv(logic ir, logic dr, logic dw, logic resp,
                               logic [AW-1:0] ia, logic [AW-1:0] da, logic [LW-1:0] wd,
                               logic e_rd, logic e_wr, logic e_ir, logic e_dr,
                               logic [AW-1:0] e_addr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.resp = resp;
    v.ia = ia; v.da = da; v.wd = wd;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_ir = e_ir; v.e_dr = e_dr;
    v.e_addr = e_addr;
    return v;
  endfunction

  vec_t vt[13];
  logic [LW-1:0] line_aa, line_55;

  // Random-phase model: owner 0 = memory idle, 1 = I-cache served, 2 = D-cache served.
  int            owner, nxt;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic          e_ir, e_dr, ip, dp;
`ifdef CACHE_ARB_RR_EN
  int            last;
`endif

  initial begin
    line_aa = {32{8'hAA}};
    line_55 = {32{8'h55}};
    //           ir dr dw rs  ia        da          wd       rd wr ir dr addr
    vt[0]  = mkv(0, 0, 0, 0, 32'h0,   32'h0,      '0,      0, 0, 0, 0, 32'h0);
    vt[1]  = mkv(1, 0, 0, 0, 32'h60,  32'h0,      '0,      0, 0, 0, 0, 32'h0);
    vt[2]  = mkv(1, 0, 0, 0, 32'h60,  32'h0,      '0,      1, 0, 0, 0, 32'h60);
    vt[3]  = mkv(1, 0, 0, 0, 32'h60,  32'h0,      '0,      1, 0, 0, 0, 32'h60);
    vt[4]  = mkv(1, 0, 0, 1, 32'h60,  32'h0,      '0,      1, 0, 1, 0, 32'h60);
    vt[5]  = mkv(0, 0, 1, 0, 32'h0,   32'h1000,   line_55, 0, 0, 0, 0, 32'h0);
    vt[6]  = mkv(0, 0, 1, 0, 32'h0,   32'h1000,   line_55, 0, 1, 0, 0, 32'h1000);
    vt[7]  = mkv(0, 0, 1, 1, 32'h0,   32'h1000,   line_55, 0, 1, 0, 1, 32'h1000);
    vt[8]  = mkv(0, 1, 1, 0, 32'h0,   32'h2000,   line_aa, 0, 0, 0, 0, 32'h0);
    vt[9]  = mkv(0, 1, 1, 0, 32'h0,   32'h2000,   line_aa, 0, 1, 0, 0, 32'h2000);
    vt[10] = mkv(0, 1, 1, 1, 32'h0,   32'h2000,   line_aa, 0, 1, 0, 1, 32'h2000);
    vt[11] = mkv(0, 0, 0, 1, 32'h0,   32'h0,      '0,      0, 0, 0, 0, 32'h0);
    vt[12] = mkv(0, 0, 0, 0, 32'h0,   32'h0,      '0,      0, 0, 0, 0, 32'h0);

    clear_inputs();
    tick();
    @(negedge clk);
    chk("rst_pmem_read",  bus.pmem_read,    '0);
    chk("rst_pmem_write", bus.pmem_write,   '0);
    chk("rst_iresp",      bus.icache_resp,  '0);
    chk("rst_dresp",      bus.dcache_resp,  '0);
    chk("rst_addr",       bus.pmem_address, '0);
    chk("rst_wdata",      bus.pmem_wdata,   '0);
    tick();
    rst = 1'b1;

    for (int i = 0; i < 13; i++) begin
      bus.icache_read    = vt[i].ir;
      bus.icache_address = vt[i].ia;
      bus.dcache_read    = vt[i].dr;
      bus.dcache_write   = vt[i].dw;
      bus.dcache_address = vt[i].da;
      bus.dcache_wdata   = vt[i].wd;
      bus.pmem_resp      = vt[i].resp;
      bus.pmem_rdata     = {8{$urandom}};
      @(negedge clk);
      chk($sformatf("vec%0d_read", i),  bus.pmem_read,   vt[i].e_rd);
      chk($sformatf("vec%0d_write", i), bus.pmem_write,  vt[i].e_wr);
      chk($sformatf("vec%0d_iresp", i), bus.icache_resp, vt[i].e_ir);
      chk($sformatf("vec%0d_dresp", i), bus.dcache_resp, vt[i].e_dr);
      chk($sformatf("vec%0d_irdata", i), bus.icache_rdata, bus.pmem_rdata);
      if (vt[i].e_rd || vt[i].e_wr)
        chk($sformatf("vec%0d_addr", i), bus.pmem_address, vt[i].e_addr);
      if (vt[i].e_wr)
        chk($sformatf("vec%0d_wdata", i), bus.pmem_wdata, vt[i].wd);
      tick();
    end
    clear_inputs();
    tick();

    // I-only read with memory answering on the 4th strobe cycle
    begin
      int n_rd = 0, n_ir = 0, n_dr = 0;
      bus.icache_read    = 1'b1;
      bus.icache_address = 32'h60;
      bus.pmem_rdata     = line_aa;
      for (int c = 0; c < 8; c++) begin
        bus.pmem_resp = bus.pmem_read && (n_rd == 3);
        @(negedge clk);
        if (bus.pmem_read) begin
          n_rd++;
          chk("ionly_addr", bus.pmem_address, 32'h60);
        end
        if (bus.icache_resp) begin
          n_ir++;
          chk("ionly_rdata", bus.icache_rdata, line_aa);
        end
        if (bus.dcache_resp) n_dr++;
        tick();
        if (n_ir > 0) bus.icache_read = 1'b0;
      end
      chk("ionly_strobe_cycles", n_rd, 4);
      chk("ionly_iresp_cycles",  n_ir, 1);
      chk("ionly_dresp_cycles",  n_dr, 0);
      clear_inputs();
    end

    // Simultaneous requests straight out of reset
    begin
      logic [AW-1:0] a1, a2;
`ifdef CACHE_ARB_RR_EN
      a1 = 32'h40; a2 = 32'h80;
`else
      a1 = 32'h80; a2 = 32'h40;
`endif
      rst = 1'b0;
      tick();
      rst = 1'b1;
      bus.icache_read = 1'b1; bus.icache_address = 32'h40;
      bus.dcache_read = 1'b1; bus.dcache_address = 32'h80;
      @(negedge clk);
      chk("sim_idle_read", bus.pmem_read, 1'b0);
      tick();
      @(negedge clk);
      chk("sim_first_read", bus.pmem_read, 1'b1);
      chk("sim_first_addr", bus.pmem_address, a1);
      tick();
      bus.pmem_resp = 1'b1;
      @(negedge clk);
      chk("sim_first_iresp", bus.icache_resp, a1 == 32'h40);
      chk("sim_first_dresp", bus.dcache_resp, a1 == 32'h80);
      tick();
      bus.pmem_resp = 1'b0;
      if (a1 == 32'h40) bus.icache_read = 1'b0;
      else              bus.dcache_read = 1'b0;
      @(negedge clk);
      chk("sim_handoff_read", bus.pmem_read, 1'b1);
      chk("sim_handoff_addr", bus.pmem_address, a2);
      tick();
      bus.pmem_resp = 1'b1;
      @(negedge clk);
      chk("sim_second_iresp", bus.icache_resp, a2 == 32'h40);
      chk("sim_second_dresp", bus.dcache_resp, a2 == 32'h80);
      tick();
      clear_inputs();
      @(negedge clk);
      chk("sim_done_read", bus.pmem_read, 1'b0);
      tick();
    end

    // Address change while D is being served must not reach pmem
    bus.dcache_read = 1'b1; bus.dcache_address = 32'h100;
    tick();
    bus.dcache_address = 32'h200;
    for (int c = 0; c < 3; c++) begin
      bus.pmem_resp = (c == 2);
      @(negedge clk);
      chk("stab_addr", bus.pmem_address, 32'h100);
      chk("stab_dresp", bus.dcache_resp, c == 2);
      tick();
    end
    clear_inputs();
    tick();

    // Reset dropped in the middle of an I read, with pmem_resp high
    bus.icache_read = 1'b1; bus.icache_address = 32'h60;
    tick();
    bus.pmem_resp = 1'b1;
    #1;
    chk("rmid_before_read", bus.pmem_read, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("rmid_async_read",  bus.pmem_read,   1'b0);
    chk("rmid_async_iresp", bus.icache_resp, 1'b0);
    clear_inputs();
    tick();
    rst = 1'b1;
    bus.icache_read = 1'b1; bus.icache_address = 32'h20;
    @(negedge clk);
    chk("rmid_idle_read", bus.pmem_read, 1'b0);
    tick();
    @(negedge clk);
    chk("rmid_fresh_read", bus.pmem_read, 1'b1);
    chk("rmid_fresh_addr", bus.pmem_address, 32'h20);
    tick();
    bus.pmem_resp = 1'b1;
    @(negedge clk);
    chk("rmid_fresh_iresp", bus.icache_resp, 1'b1);
    tick();
    clear_inputs();

    // Randomized traffic against the ownership model
    rst = 1'b0;
    tick();
    rst = 1'b1;
    owner = 0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
`ifdef CACHE_ARB_RR_EN
    last = 2;
`endif
    for (int c = 0; c < 800; c++) begin
      if (!bus.icache_read && $urandom_range(0, 2) == 0) begin
        bus.icache_read    = 1'b1;
        bus.icache_address = $urandom & 32'hffff_ffe0;
      end
      if (!(bus.dcache_read || bus.dcache_write) && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        bus.dcache_read    = (op != 1);
        bus.dcache_write   = (op != 0);
        bus.dcache_address = $urandom & 32'hffff_ffe0;
        bus.dcache_wdata   = {8{$urandom}};
      end
      bus.pmem_resp  = ($urandom_range(0, 3) == 0);
      bus.pmem_rdata = {8{$urandom}};
      @(negedge clk);
      e_ir = (owner == 1) && bus.pmem_resp;
      e_dr = (owner == 2) && bus.pmem_resp;
      chk("rnd_read",   bus.pmem_read,   (owner == 1) || (owner == 2 && !m_write));
      chk("rnd_write",  bus.pmem_write,  (owner == 2) && m_write);
      chk("rnd_iresp",  bus.icache_resp, e_ir);
      chk("rnd_dresp",  bus.dcache_resp, e_dr);
      chk("rnd_drdata", bus.dcache_rdata, bus.pmem_rdata);
      if (owner != 0) chk("rnd_addr", bus.pmem_address, m_addr);
      if (owner == 2 && m_write) chk("rnd_wdata", bus.pmem_wdata, m_wdata);

      ip  = bus.icache_read;
      dp  = bus.dcache_read | bus.dcache_write;
      nxt = owner;
      if (owner == 0) begin
        if (ip && dp) begin
`ifdef CACHE_ARB_RR_EN
          nxt = (last == 2) ? 1 : 2;
`else
          nxt = 2;
`endif
        end else if (ip) nxt = 1;
        else if (dp)     nxt = 2;
      end else if (bus.pmem_resp) begin
        if (owner == 1) nxt = dp ? 2 : 0;
        else            nxt = ip ? 1 : 0;
      end
      if (nxt == 1 && owner != 1) begin
        m_addr = bus.icache_address; m_write = 1'b0;
      end else if (nxt == 2 && owner != 2) begin
        m_addr = bus.dcache_address; m_write = bus.dcache_write; m_wdata = bus.dcache_wdata;
      end
`ifdef CACHE_ARB_RR_EN
      if (nxt != 0 && nxt != owner) last = nxt;
`endif
      tick();
      owner = nxt;
      if (e_ir) bus.icache_read = 1'b0;
      if (e_dr) begin
        bus.dcache_read  = 1'b0;
        bus.dcache_write = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
